// File: rtl/ac_actuator.sv
// ac_actuator: fan PWM driver with soft-start ramp, compressor flag and room temperature model.
// Define AC_ACTUATOR_SOFT_START_EN to ramp the fan speed; otherwise speed jumps at the next frame end.
module ac_actuator #(
  parameter int PWM_PERIOD       = 16,
  parameter int RAMP_FRAMES      = 4,
  parameter int HEAT_STEP_FRAMES = 32,
  parameter int TEMP_INIT        = 24,
  parameter int AMBIENT          = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] fan_speed,
  input  logic [7:0] fan_heat,
  output logic       fan_pwm,
  output logic [2:0] applied_speed,
  output logic       ramping,
  output logic       compressor_on,
  output logic [6:0] temperature
);
  localparam int CW = $clog2(PWM_PERIOD);
  localparam int HW = $clog2(HEAT_STEP_FRAMES + 1);
  logic [CW-1:0] count_q, count_d;
  logic [2:0] applied_q, applied_d, target;
  logic [6:0] temp_q, temp_d, outlet, goal;
  logic [HW-1:0] heat_q, heat_d;
  logic [8:0] thr;
  logic pwm_q, pwm_d, comp_q, comp_d, ramp_q, ramp_d, frame_end, heat_tick;
  assign target    = fan_speed > 3'd4 ? 3'd4 : fan_speed;
  assign outlet    = fan_heat[7] ? 7'd0 : fan_heat[6:0];
  assign frame_end = count_q == CW'(PWM_PERIOD - 1);
  assign count_d   = count_q + 1'b1;
`ifdef AC_ACTUATOR_SOFT_START_EN
  localparam int TW = $clog2(RAMP_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  state_t state_q, state_d, state_c;
  logic [TW-1:0] tally_q, tally_d;
  logic same, step;
  // state_c is the direction implied by this cycle's request; a mismatch with state_q restarts the tally
  always_comb begin
    state_c   = target > applied_q ? UP : target < applied_q ? DOWN : IDLE;
    same      = state_c == state_q;
    step      = same && state_c != IDLE && frame_end && tally_q == TW'(RAMP_FRAMES - 1);
    applied_d = target == 3'd0 ? 3'd0 : !step ? applied_q : state_c == UP ? applied_q + 3'd1 : applied_q - 3'd1;
    tally_d   = (target == 3'd0 || !same || step) ? '0 : frame_end ? tally_q + 1'b1 : tally_q;
    state_d   = target > applied_d ? UP : target < applied_d ? DOWN : IDLE;
    ramp_d    = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tally_q <= '0;
    end else begin
      state_q <= state_d;
      tally_q <= tally_d;
    end
  end
`else
  always_comb begin
    applied_d = target == 3'd0 ? 3'd0 : frame_end ? target : applied_q;
    ramp_d    = 1'b0;
  end
`endif
  // PWM is computed from next-cycle count/speed so fan_pwm lines up with the frame it belongs to
  always_comb begin
    thr       = {6'd0, applied_d} * 9'(PWM_PERIOD / 4);
    pwm_d     = {{(9 - CW){1'b0}}, count_d} < thr;
    comp_d    = applied_q != 3'd0 && outlet < temp_q;
    goal      = applied_q != 3'd0 ? outlet : 7'(AMBIENT);
    heat_tick = frame_end && heat_q == HW'(HEAT_STEP_FRAMES - 1);
    heat_d    = !frame_end ? heat_q : heat_tick ? '0 : heat_q + 1'b1;
    temp_d    = !heat_tick ? temp_q : temp_q < goal ? temp_q + 7'd1 : temp_q > goal ? temp_q - 7'd1 : temp_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      applied_q <= '0;
      pwm_q     <= 1'b0;
      comp_q    <= 1'b0;
      ramp_q    <= 1'b0;
      heat_q    <= '0;
      temp_q    <= 7'(TEMP_INIT);
    end else begin
      count_q   <= count_d;
      applied_q <= applied_d;
      pwm_q     <= pwm_d;
      comp_q    <= comp_d;
      ramp_q    <= ramp_d;
      heat_q    <= heat_d;
      temp_q    <= temp_d;
    end
  end
  assign fan_pwm       = pwm_q;
  assign applied_speed = applied_q;
  assign ramping       = ramp_q;
  assign compressor_on = comp_q;
  assign temperature   = temp_q;
endmodule
